mem_port_arbiter: RTL and testbench

//   Shares the single-port unified memory inside Top between two requesters: the

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch unit (IF) and
//   the load/store unit (D). Only one transaction is in flight at a time.
//   When both ports request together, the port that was not granted last
//   wins. Read data, or a write ack, returns to the owning port MEM_LATENCY
//   cycles after the grant.
//
// Parameters
//   ADDR_WIDTH   byte-address width
//   DATA_WIDTH   data width, multiple of 8
//   MEM_LATENCY  cycles from mem_en to valid mem_rdata, 1..15
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   if_req/if_addr               IF read request, held until if_gnt
//   if_gnt                       IF accepted this cycle (combinational)
//   if_rvalid/if_rdata           IF read data return (one-cycle pulse)
//   d_req/d_we/d_be/d_addr/
//   d_wdata                      D request, held until d_gnt
//   d_gnt                        D accepted this cycle (combinational)
//   d_rvalid/d_rdata             D read data or write ack (rdata 0 on ack)
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata           memory request, one-cycle strobe per access
//   mem_rdata                    memory read data, MEM_LATENCY after mem_en
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,

  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int         BE_W = DATA_WIDTH / 8;
  localparam logic [3:0] LAT  = 4'(MEM_LATENCY);

  typedef enum logic { S_IDLE, S_WAIT } state_t;
  typedef enum logic { OWN_IF, OWN_D }  owner_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  owner_t     r_last;   // port granted most recently (arbitration history)
  owner_t     r_owner;  // port that owns the in-flight transaction
  logic       r_we;     // in-flight transaction is a D write

  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic w_if_gnt;
  logic w_d_gnt;
  logic w_done;
  logic w_if_rvalid;
  logic w_d_rvalid;
  logic [DATA_WIDTH-1:0] w_d_ret;

  // -------------------------------------------------------------------------
  // Next state, grants and completion
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_if_gnt    = 1'b0;
    w_d_gnt     = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // IF wins when alone, or on a conflict if D was served last.
        if (if_req && (!d_req || r_last == OWN_D))
          w_if_gnt = 1'b1;
        else if (d_req)
          w_d_gnt = 1'b1;

        if (w_if_gnt || w_d_gnt) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 4'd1;
        end
      end

      S_WAIT: begin
        // Completion cycle: data returns, no grant, back to IDLE.
        if (r_cnt == LAT) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // Reset silences everything in the same cycle, including an in-flight
    // completion, so an abandoned transaction never returns.
    if (reset) begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
      w_done   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_last     <= OWN_D;
      r_owner    <= OWN_D;
      r_we       <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;

      if (w_if_gnt) begin
        r_last  <= OWN_IF;
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
      end else if (w_d_gnt) begin
        r_last  <= OWN_D;
        r_owner <= OWN_D;
        r_we    <= d_we;
      end

      // Hold the returned data until the next return to the same port.
      if (w_if_rvalid) r_if_rdata <= mem_rdata;
      if (w_d_rvalid)  r_d_rdata  <= w_d_ret;
    end
  end

  // -------------------------------------------------------------------------
  // Return path: routed to the registered owner, not to whoever requests now
  // -------------------------------------------------------------------------
  assign w_if_rvalid = w_done && (r_owner == OWN_IF);
  assign w_d_rvalid  = w_done && (r_owner == OWN_D);
  assign w_d_ret     = r_we ? '0 : mem_rdata;

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = w_if_rvalid;
  assign d_rvalid  = w_d_rvalid;

  // The completion cycle passes mem_rdata straight through; afterwards the
  // held copy is shown.
  assign if_rdata = reset       ? '0        :
                    w_if_rvalid ? mem_rdata : r_if_rdata;
  assign d_rdata  = reset       ? '0        :
                    w_d_rvalid  ? w_d_ret   : r_d_rdata;

  // -------------------------------------------------------------------------
  // Memory request mux; buses are don't-care while mem_en is low
  // -------------------------------------------------------------------------
  assign mem_en    = w_if_gnt || w_d_gnt;
  assign mem_we    = w_d_gnt && d_we;
  assign mem_be    = w_d_gnt ? d_be   : {BE_W{1'b1}};
  assign mem_addr  = w_d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;

  // LAT=1 instance
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1, drv_rdata1;
  logic [3:0]  mem_be1;
  // LAT=3 instance
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_be3;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Small memory model for the LAT=1 instance (16 words, addr[5:2]).
  logic        use_model;
  logic [31:0] mem_arr [16];
  logic [31:0] rd_q;
  assign mem_rdata1 = use_model ? rd_q : drv_rdata1;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  always @(posedge clock) begin
    if (!use_model) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
    end else if (mem_en1) begin
      if (mem_we1) begin
        for (int b = 0; b < 4; b++)
          if (mem_be1[b]) mem_arr[mem_addr1[5:2]][b*8 +: 8] <= mem_wdata1[b*8 +: 8];
      end else begin
        rd_q <= mem_arr[mem_addr1[5:2]];
      end
    end
  end

  typedef struct { bit port; logic [31:0] data; } sb_t;
  sb_t         sb[$];
  sb_t         e;
  logic [31:0] ref_mem [16];
  int          checks = 0;
  int          fails  = 0;
  logic        exp_if, exp_d;
  int          m_cnt;
  bit          m_last;
  int          last_en;
  logic [3:0]  idx;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt(); @(posedge clock); #1; endtask
  task automatic smp(); @(negedge clock); endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = 4'hF; d_addr = '0; d_wdata = '0; drv_rdata1 = '0; mem_rdata3 = '0;
    use_model = 1'b0;

    // ---- 1: reset outputs, then single IF read (LAT=1) ----
    nxt();
    if_req = 1'b1; if_addr = 32'h100;
    smp();
    chk("rst_if_gnt", {31'd0, if_gnt1}, 0);
    chk("rst_mem_en", {31'd0, mem_en1}, 0);
    chk("rst_if_rdata", if_rdata1, 0);
    chk("rst_d_rdata", d_rdata1, 0);
    nxt();
    reset = 1'b0; drv_rdata1 = 32'hDEADBEEF;
    smp();
    chk("t1_if_gnt", {31'd0, if_gnt1}, 1);
    chk("t1_mem_en", {31'd0, mem_en1}, 1);
    chk("t1_mem_addr", mem_addr1, 32'h100);
    chk("t1_mem_we", {31'd0, mem_we1}, 0);
    chk("t1_mem_be", {28'd0, mem_be1}, 32'hF);
    nxt();
    if_req = 1'b0;
    smp();
    chk("t1_if_rvalid", {31'd0, if_rvalid1}, 1);
    chk("t1_if_rdata", if_rdata1, 32'hDEADBEEF);
    chk("t1_no_gnt", {30'd0, if_gnt1, d_gnt1}, 0);
    nxt();
    drv_rdata1 = 32'h0;
    smp();
    chk("t1_rvalid_pulse", {31'd0, if_rvalid1}, 0);
    chk("t1_rdata_hold", if_rdata1, 32'hDEADBEEF);

    // ---- 2: conflicts alternate IF, D, IF, D ----
    reset = 1'b1;
    nxt();
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      drv_rdata1 = 32'hA000_0000 + 32'(k);
      smp();
      chk("t2_if_gnt", {31'd0, if_gnt1}, (k % 2 == 0) ? 1 : 0);
      chk("t2_d_gnt", {31'd0, d_gnt1}, (k % 2 == 1) ? 1 : 0);
      chk("t2_mem_addr", mem_addr1, (k % 2 == 0) ? 32'h104 : 32'h300);
      nxt();
      smp();
      chk("t2_if_rvalid", {31'd0, if_rvalid1}, (k % 2 == 0) ? 1 : 0);
      chk("t2_d_rvalid", {31'd0, d_rvalid1}, (k % 2 == 1) ? 1 : 0);
      chk("t2_rdata", (k % 2 == 0) ? if_rdata1 : d_rdata1, 32'hA000_0000 + 32'(k));
      chk("t2_no_gnt", {30'd0, if_gnt1, d_gnt1}, 0);
      nxt();
    end

    // ---- 3: D write with partial byte enables ----
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
    d_wdata = 32'h12345678; d_be = 4'b0011; drv_rdata1 = 32'hFFFF_FFFF;
    smp();
    chk("t3_d_gnt", {31'd0, d_gnt1}, 1);
    chk("t3_mem_we", {31'd0, mem_we1}, 1);
    chk("t3_mem_be", {28'd0, mem_be1}, 32'h3);
    chk("t3_mem_addr", mem_addr1, 32'h200);
    chk("t3_mem_wdata", mem_wdata1, 32'h12345678);
    nxt();
    d_req = 1'b0;
    smp();
    chk("t3_d_rvalid", {31'd0, d_rvalid1}, 1);
    chk("t3_d_rdata", d_rdata1, 0);
    chk("t3_if_rvalid", {31'd0, if_rvalid1}, 0);

    // ---- 4: LAT=3 D read, blocked second request ----
    reset = 1'b1;
    nxt();
    reset = 1'b0; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
    d_wdata = 32'h55; mem_rdata3 = 32'h0BADF00D;
    smp();
    chk("t4_d_gnt0", {31'd0, d_gnt3}, 1);
    chk("t4_mem_en", {31'd0, mem_en3}, 1);
    chk("t4_mem_addr", mem_addr3, 32'h400);
    chk("t4_mem_we", {31'd0, mem_we3}, 0);
    chk("t4_mem_be", {28'd0, mem_be3}, 32'hF);
    chk("t4_mem_wdata", mem_wdata3, 32'h55);
    for (int c = 1; c <= 3; c++) begin
      nxt();
      smp();
      chk("t4_d_gnt_wait", {31'd0, d_gnt3}, 0);
      chk("t4_mem_en_wait", {31'd0, mem_en3}, 0);
      chk("t4_d_rvalid", {31'd0, d_rvalid3}, (c == 3) ? 1 : 0);
    end
    chk("t4_d_rdata", d_rdata3, 32'h0BADF00D);
    nxt();
    smp();
    chk("t4_d_gnt4", {31'd0, d_gnt3}, 1);
    nxt();
    d_req = 1'b0;

    // ---- 5: reset mid-WAIT abandons the transaction ----
    reset = 1'b1;
    nxt();
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    smp();
    chk("t5_if_gnt", {31'd0, if_gnt3}, 1);
    chk("t5_d_rdata_rst", d_rdata3, 0);
    chk("t5_if_rdata_rst", if_rdata3, 0);
    nxt();
    reset = 1'b1; if_req = 1'b0;
    smp();
    chk("t5_rst_rvalid", {31'd0, if_rvalid3}, 0);
    chk("t5_rst_mem_en", {31'd0, mem_en3}, 0);
    nxt();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("t5_no_rvalid", {30'd0, if_rvalid3, d_rvalid3}, 0);
      nxt();
    end
    if_req = 1'b1; d_req = 1'b1;
    smp();
    chk("t5_conf_if", {31'd0, if_gnt3}, 1);
    chk("t5_conf_d", {31'd0, d_gnt3}, 0);
    nxt();
    if_req = 1'b0; d_req = 1'b0;

    // ---- 6: random traffic vs scoreboard (LAT=1) ----
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    reset = 1'b1;
    nxt();
    reset = 1'b0; use_model = 1'b1;
    m_cnt = 0; m_last = 1'b1; last_en = -100;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!if_req && $urandom_range(1, 0) == 1) begin
        if_req = 1'b1; idx = 4'($urandom_range(15, 0)); if_addr = {26'd0, idx, 2'b00};
      end
      if (!d_req && $urandom_range(1, 0) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1, 0)); d_be = 4'($urandom_range(15, 1));
        idx = 4'($urandom_range(15, 0)); d_addr = {26'd0, idx, 2'b00}; d_wdata = $urandom;
      end
      smp();
      exp_if = (m_cnt == 0) && if_req && (!d_req || m_last);
      exp_d  = (m_cnt == 0) && d_req && (!if_req || !m_last);
      chk("rnd_if_gnt", {31'd0, if_gnt1}, {31'd0, exp_if});
      chk("rnd_d_gnt", {31'd0, d_gnt1}, {31'd0, exp_d});
      chk("rnd_mem_en", {31'd0, mem_en1}, {31'd0, exp_if | exp_d});
      if (mem_en1) begin
        chk("rnd_spacing", (cyc - last_en > 1) ? 1 : 0, 1);
        last_en = cyc;
      end
      if (m_cnt == 1) begin
        chk("rnd_sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rnd_if_rvalid", {31'd0, if_rvalid1}, e.port ? 0 : 1);
          chk("rnd_d_rvalid", {31'd0, d_rvalid1}, e.port ? 1 : 0);
          chk("rnd_rdata", e.port ? d_rdata1 : if_rdata1, e.data);
        end
      end else begin
        chk("rnd_no_rvalid", {30'd0, if_rvalid1, d_rvalid1}, 0);
      end
      if (exp_if) begin
        e.port = 1'b0; e.data = ref_mem[if_addr[5:2]]; sb.push_back(e);
        chk("rnd_if_addr", mem_addr1, if_addr);
        chk("rnd_if_we", {31'd0, mem_we1}, 0);
      end
      if (exp_d) begin
        e.port = 1'b1;
        if (d_we) begin
          e.data = 32'd0;
          for (int b = 0; b < 4; b++)
            if (d_be[b]) ref_mem[d_addr[5:2]][b*8 +: 8] = d_wdata[b*8 +: 8];
        end else begin
          e.data = ref_mem[d_addr[5:2]];
        end
        sb.push_back(e);
        chk("rnd_d_addr", mem_addr1, d_addr);
        chk("rnd_d_we", {31'd0, mem_we1}, {31'd0, d_we});
      end
      if (exp_if || exp_d) begin
        m_cnt = 1; m_last = exp_d;
      end else if (m_cnt == 1) begin
        m_cnt = 0;
      end
      nxt();
      if (exp_if) if_req = 1'b0;
      if (exp_d)  d_req  = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    smp();
    if (m_cnt == 1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rnd_last_rvalid", {30'd0, d_rvalid1, if_rvalid1}, e.port ? 2 : 1);
    end
    chk("rnd_drain", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
